// File: rtl/fix_pkg.sv
// Shared helpers and types for the complex add/sub scheduler.
// Tag width covers the largest supported requester count (8).
package fix_pkg;

    localparam int unsigned MAX_REQ = 8;

    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned dp_lat(input int unsigned sat_p,
                                           input int unsigned shift_p,
                                           input int unsigned add_p);
        return sat_p + shift_p + add_p;
    endfunction

    localparam int unsigned ID_W = id_w(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fix_c_add_sub.sv
// Pipelined complex fixed-point add/sub: add -> arithmetic right shift ->
// saturate, each stage followed by a configurable number of registers.
module fix_c_add_sub #(
    parameter  int unsigned IN_WIDTH     = 16,
    parameter  int unsigned OUT_WIDTH    = 16,
    parameter  int unsigned SHIFT_CONST  = 3,
    parameter  int unsigned SHIFT_MODE   = 1,
    parameter  int unsigned ARITH_MODE_R = 2,
    parameter  int unsigned ARITH_MODE_I = 2,
    parameter  int unsigned FLIP         = 0,
    parameter  int unsigned SAT_PIPE     = 1,
    parameter  int unsigned SHIFT_PIPE   = 1,
    parameter  int unsigned ADD_PIPE     = 1,
    localparam int unsigned SH_W         = $clog2(IN_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  i_opa_R,
    input  logic [IN_WIDTH-1:0]  i_opa_I,
    input  logic [IN_WIDTH-1:0]  i_opb_R,
    input  logic [IN_WIDTH-1:0]  i_opb_I,
    input  logic                 i_arith_mode_R,
    input  logic                 i_arith_mode_I,
    input  logic [SH_W-1:0]      i_shift_amount,
    output logic [OUT_WIDTH-1:0] o_res_R,
    output logic [OUT_WIDTH-1:0] o_res_I
);

    localparam int unsigned SUM_W = IN_WIDTH + 1;
    localparam int unsigned EXT_W = ((SUM_W > OUT_WIDTH) ? SUM_W : OUT_WIDTH) + 1;
    localparam int unsigned ADD_W = 2 * SUM_W + SH_W;
    localparam int unsigned SHF_W = 2 * SUM_W;
    localparam int unsigned SAT_W = 2 * OUT_WIDTH;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    // Full-precision add/sub; FLIP swaps the operand order.
    function automatic logic [SUM_W-1:0] addsub(input logic [IN_WIDTH-1:0] a,
                                                input logic [IN_WIDTH-1:0] b,
                                                input logic                sub);
        logic signed [SUM_W-1:0] x;
        logic signed [SUM_W-1:0] y;
        if (FLIP != 0) begin
            x = SUM_W'($signed(b));
            y = SUM_W'($signed(a));
        end else begin
            x = SUM_W'($signed(a));
            y = SUM_W'($signed(b));
        end
        return sub ? (x - y) : (x + y);
    endfunction

    function automatic logic [OUT_WIDTH-1:0] sat(input logic [SUM_W-1:0] v);
        logic signed [EXT_W-1:0] x;
        x = EXT_W'($signed(v));
        if (x > SAT_MAX) return {1'b0, {(OUT_WIDTH-1){1'b1}}};
        if (x < SAT_MIN) return {1'b1, {(OUT_WIDTH-1){1'b0}}};
        return OUT_WIDTH'(x);
    endfunction

    logic                    w_sub_R;
    logic                    w_sub_I;
    logic [SH_W-1:0]         w_shamt_d;
    logic [ADD_W-1:0]        w_add_d;
    logic [ADD_W-1:0]        w_add_q;
    logic signed [SUM_W-1:0] w_sum_R;
    logic signed [SUM_W-1:0] w_sum_I;
    logic [SH_W-1:0]         w_shamt_q;
    logic [SHF_W-1:0]        w_shf_d;
    logic [SHF_W-1:0]        w_shf_q;
    logic [SAT_W-1:0]        w_sat_d;
    logic [SAT_W-1:0]        w_sat_q;

    assign w_sub_R   = (ARITH_MODE_R == 2) ? i_arith_mode_R : (ARITH_MODE_R == 1);
    assign w_sub_I   = (ARITH_MODE_I == 2) ? i_arith_mode_I : (ARITH_MODE_I == 1);
    assign w_shamt_d = (SHIFT_MODE != 0) ? i_shift_amount : SH_W'(SHIFT_CONST);

    assign w_add_d = {addsub(i_opa_R, i_opb_R, w_sub_R),
                      addsub(i_opa_I, i_opb_I, w_sub_I),
                      w_shamt_d};

    generate
        if (ADD_PIPE == 0) begin : g_add_comb
            assign w_add_q = w_add_d;
        end else begin : g_add_reg
            logic [ADD_W-1:0] r_q [ADD_PIPE];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < ADD_PIPE; k++) r_q[k] <= '0;
                end else begin
                    r_q[0] <= w_add_d;
                    for (int unsigned k = 1; k < ADD_PIPE; k++) r_q[k] <= r_q[k-1];
                end
            end
            assign w_add_q = r_q[ADD_PIPE-1];
        end
    endgenerate

    // The shift amount travels with its sums so each op uses its own value.
    assign {w_sum_R, w_sum_I, w_shamt_q} = w_add_q;
    assign w_shf_d = {w_sum_R >>> w_shamt_q, w_sum_I >>> w_shamt_q};

    generate
        if (SHIFT_PIPE == 0) begin : g_shf_comb
            assign w_shf_q = w_shf_d;
        end else begin : g_shf_reg
            logic [SHF_W-1:0] r_q [SHIFT_PIPE];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < SHIFT_PIPE; k++) r_q[k] <= '0;
                end else begin
                    r_q[0] <= w_shf_d;
                    for (int unsigned k = 1; k < SHIFT_PIPE; k++) r_q[k] <= r_q[k-1];
                end
            end
            assign w_shf_q = r_q[SHIFT_PIPE-1];
        end
    endgenerate

    assign w_sat_d = {sat(w_shf_q[SHF_W-1:SUM_W]), sat(w_shf_q[SUM_W-1:0])};

    generate
        if (SAT_PIPE == 0) begin : g_sat_comb
            assign w_sat_q = w_sat_d;
        end else begin : g_sat_reg
            logic [SAT_W-1:0] r_q [SAT_PIPE];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < SAT_PIPE; k++) r_q[k] <= '0;
                end else begin
                    r_q[0] <= w_sat_d;
                    for (int unsigned k = 1; k < SAT_PIPE; k++) r_q[k] <= r_q[k-1];
                end
            end
            assign w_sat_q = r_q[SAT_PIPE-1];
        end
    endgenerate

    assign o_res_R = w_sat_q[SAT_W-1:OUT_WIDTH];
    assign o_res_I = w_sat_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/fix_rr_arb.sv
// Round-robin arbiter: scans from last+1, grants one requester per cycle
// while enabled, and advances the pointer only on a grant.
module fix_rr_arb
    import fix_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned GID_W   = id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [GID_W-1:0]   o_gnt_id
);

    logic [GID_W-1:0] r_last;
    logic [GID_W-1:0] w_idx;
    logic             w_found;

    // First valid requester after the pointer wins; nothing while in reset.
    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        if (rst_n && i_en) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                w_idx = GID_W'((32'(r_last) + k) % NUM_REQ);
                if (!w_found && i_req[w_idx]) begin
                    w_found     = 1'b1;
                    o_gnt[w_idx] = 1'b1;
                    o_gnt_id    = w_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= GID_W'(NUM_REQ - 1);
        end else if (w_found) begin
            r_last <= o_gnt_id;
        end
    end

endmodule

// File: rtl/fix_c_add_sub_arb.sv
// Shares one complex add/sub datapath among NUM_REQ requesters; results
// come back tagged with the requester ID that issued them.
module fix_c_add_sub_arb
    import fix_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned IN_WIDTH    = 16,
    parameter  int unsigned OUT_WIDTH   = 16,
    parameter  int unsigned SHIFT_CONST = 3,
    parameter  int unsigned SHIFT_MODE  = 1,
    parameter  int unsigned SAT_PIPE    = 1,
    parameter  int unsigned SHIFT_PIPE  = 1,
    parameter  int unsigned ADD_PIPE    = 1,
    localparam int unsigned RID_W       = id_w(NUM_REQ),
    localparam int unsigned SH_W        = $clog2(IN_WIDTH + 1),
    localparam int unsigned DP_LAT      = dp_lat(SAT_PIPE, SHIFT_PIPE, ADD_PIPE)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_en,
    input  logic [SH_W-1:0]               i_shift_amount,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*IN_WIDTH-1:0]   i_req_opa_R,
    input  logic [NUM_REQ*IN_WIDTH-1:0]   i_req_opa_I,
    input  logic [NUM_REQ*IN_WIDTH-1:0]   i_req_opb_R,
    input  logic [NUM_REQ*IN_WIDTH-1:0]   i_req_opb_I,
    input  logic [NUM_REQ-1:0]            i_req_sub_R,
    input  logic [NUM_REQ-1:0]            i_req_sub_I,
    output logic                          o_res_valid,
    output logic [RID_W-1:0]              o_res_id,
    output logic [OUT_WIDTH-1:0]          o_res_R,
    output logic [OUT_WIDTH-1:0]          o_res_I,
    output logic                          o_busy
);

    logic [NUM_REQ-1:0]   w_gnt;
    logic [RID_W-1:0]     w_gnt_id;
    logic [IN_WIDTH-1:0]  w_opa_R, w_opa_I, w_opb_R, w_opb_I;
    logic                 w_sub_R, w_sub_I;

    logic                 r_iss_v;
    logic [RID_W-1:0]     r_iss_id;
    logic [IN_WIDTH-1:0]  r_opa_R, r_opa_I, r_opb_R, r_opb_I;
    logic                 r_sub_R, r_sub_I;
    logic [SH_W-1:0]      r_shift;

    logic [OUT_WIDTH-1:0] w_dp_R, w_dp_I;
    tag_t                 w_tag_in;
    tag_t                 w_tag_last;
    logic                 w_tag_busy;

    fix_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (i_en),
        .i_req    (i_req_valid),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    assign o_req_ready = w_gnt;

    // One-hot operand select for the winning requester.
    always_comb begin
        w_opa_R = '0;
        w_opa_I = '0;
        w_opb_R = '0;
        w_opb_I = '0;
        w_sub_R = 1'b0;
        w_sub_I = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_opa_R = i_req_opa_R[i*IN_WIDTH +: IN_WIDTH];
                w_opa_I = i_req_opa_I[i*IN_WIDTH +: IN_WIDTH];
                w_opb_R = i_req_opb_R[i*IN_WIDTH +: IN_WIDTH];
                w_opb_I = i_req_opb_I[i*IN_WIDTH +: IN_WIDTH];
                w_sub_R = i_req_sub_R[i];
                w_sub_I = i_req_sub_I[i];
            end
        end
    end

    // Issue register: operands hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_v  <= 1'b0;
            r_iss_id <= '0;
            r_opa_R  <= '0;
            r_opa_I  <= '0;
            r_opb_R  <= '0;
            r_opb_I  <= '0;
            r_sub_R  <= 1'b0;
            r_sub_I  <= 1'b0;
            r_shift  <= '0;
        end else begin
            r_iss_v <= |w_gnt;
            if (|w_gnt) begin
                r_iss_id <= w_gnt_id;
                r_opa_R  <= w_opa_R;
                r_opa_I  <= w_opa_I;
                r_opb_R  <= w_opb_R;
                r_opb_I  <= w_opb_I;
                r_sub_R  <= w_sub_R;
                r_sub_I  <= w_sub_I;
                r_shift  <= i_shift_amount;
            end
        end
    end

    fix_c_add_sub #(
        .IN_WIDTH     (IN_WIDTH),
        .OUT_WIDTH    (OUT_WIDTH),
        .SHIFT_CONST  (SHIFT_CONST),
        .SHIFT_MODE   (SHIFT_MODE),
        .ARITH_MODE_R (2),
        .ARITH_MODE_I (2),
        .FLIP         (0),
        .SAT_PIPE     (SAT_PIPE),
        .SHIFT_PIPE   (SHIFT_PIPE),
        .ADD_PIPE     (ADD_PIPE)
    ) u_dp (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_opa_R        (r_opa_R),
        .i_opa_I        (r_opa_I),
        .i_opb_R        (r_opb_R),
        .i_opb_I        (r_opb_I),
        .i_arith_mode_R (r_sub_R),
        .i_arith_mode_I (r_sub_I),
        .i_shift_amount (r_shift),
        .o_res_R        (w_dp_R),
        .o_res_I        (w_dp_I)
    );

    assign w_tag_in = {r_iss_v, ID_W'(r_iss_id)};

    // Tag pipeline mirrors the datapath depth so the ID lines up with its result.
    generate
        if (DP_LAT == 0) begin : g_tag_none
            assign w_tag_last = w_tag_in;
            assign w_tag_busy = 1'b0;
        end else begin : g_tag_pipe
            tag_t r_tag [DP_LAT];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < DP_LAT; k++) r_tag[k] <= '0;
                end else begin
                    r_tag[0] <= w_tag_in;
                    for (int unsigned k = 1; k < DP_LAT; k++) r_tag[k] <= r_tag[k-1];
                end
            end
            always_comb begin
                w_tag_busy = 1'b0;
                for (int unsigned k = 0; k < DP_LAT; k++) w_tag_busy |= r_tag[k].valid;
            end
            assign w_tag_last = r_tag[DP_LAT-1];
        end
    endgenerate

    assign o_res_valid = w_tag_last.valid;
    assign o_res_id    = RID_W'(w_tag_last.id);
    assign o_res_R     = w_tag_last.valid ? w_dp_R : '0;
    assign o_res_I     = w_tag_last.valid ? w_dp_I : '0;
    assign o_busy      = r_iss_v | w_tag_busy;

endmodule
